pipelined_normalizer: RTL

- Parametrised, two-stage pipelined leading-zero normaliser for the floating-point adder datapath.
- Successor to the fixed 24-bit combinational leading-zero counter: adds generic width, a left-shift and exponent adjust, denormal clamping, and valid/ready flow control.
- Sits after the mantissa add/subtract stage and feeds rounding/packing.

---
 rtl/pipelined_normalizer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipelined_normalizer.sv
// Two-stage leading-zero normaliser: stage 1 counts leading zeros, stage 2 shifts
// and adjusts the exponent with denormal clamping. NORM_STATS_EN adds transfer counters.
module pipelined_normalizer #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_norm_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [CNT_W-1:0] out_lzc,
  output logic             out_zero,
  output logic             out_uflow
`ifdef NORM_STATS_EN
  ,
  output logic [15:0]      stat_uflow_cnt,
  output logic [15:0]      stat_zero_cnt
`endif
);

  localparam int SW = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  logic             r1_valid;
  logic [WIDTH-1:0] r1_mant;
  logic [EXP_W-1:0] r1_exp;
  logic             r1_en;
  logic [CNT_W-1:0] r1_lzc;
  logic             r1_zero;

  logic             r2_valid;
  logic [WIDTH-1:0] r2_mant;
  logic [EXP_W-1:0] r2_exp;
  logic [CNT_W-1:0] r2_lzc;
  logic             r2_zero;
  logic             r2_uflow;

  logic             w_s2_free;
  logic             w_in_ready;
  logic [CNT_W-1:0] w_lzc_raw;
  logic [CNT_W-1:0] w_lzc;
  logic             w_zero;
  logic [SW-1:0]    w_lzc_x;
  logic [SW-1:0]    w_exp_x;
  logic [SW-1:0]    w_sh;
  logic             w_uflow;
  logic [WIDTH-1:0] w_mant_n;
  logic [EXP_W-1:0] w_exp_n;

  assign w_s2_free  = !r2_valid || out_ready;
  assign w_in_ready = !r1_valid || w_s2_free;

  // Later (higher) set bits overwrite earlier ones, leaving the MSB position.
  always_comb begin
    w_lzc_raw = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_mant[i]) w_lzc_raw = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign w_zero = (in_mant == '0);
  assign w_lzc  = in_norm_en ? w_lzc_raw : '0;

  assign w_lzc_x = SW'(r1_lzc);
  assign w_exp_x = SW'(r1_exp);
  assign w_sh    = (w_lzc_x < w_exp_x) ? w_lzc_x : w_exp_x;
  assign w_uflow = (w_lzc_x > w_exp_x) && !r1_zero && r1_en;

  // A normalised zero has no meaningful exponent, so it is forced to 0.
  always_comb begin
    w_mant_n = r1_mant << w_sh;
    w_exp_n  = r1_exp - EXP_W'(w_sh);
    if (r1_zero && r1_en) begin
      w_mant_n = '0;
      w_exp_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_mant  <= '0;
      r1_exp   <= '0;
      r1_en    <= 1'b0;
      r1_lzc   <= '0;
      r1_zero  <= 1'b0;
      r2_valid <= 1'b0;
      r2_mant  <= '0;
      r2_exp   <= '0;
      r2_lzc   <= '0;
      r2_zero  <= 1'b0;
      r2_uflow <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r1_valid <= in_valid;
        if (in_valid) begin
          r1_mant <= in_mant;
          r1_exp  <= in_exp;
          r1_en   <= in_norm_en;
          r1_lzc  <= w_lzc;
          r1_zero <= w_zero;
        end
      end
      if (w_s2_free) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_mant  <= w_mant_n;
          r2_exp   <= w_exp_n;
          r2_lzc   <= r1_lzc;
          r2_zero  <= r1_zero;
          r2_uflow <= w_uflow;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r2_valid;
  assign out_mant  = r2_mant;
  assign out_exp   = r2_exp;
  assign out_lzc   = r2_lzc;
  assign out_zero  = r2_zero;
  assign out_uflow = r2_uflow;

`ifdef NORM_STATS_EN
  logic        w_out_fire;
  logic [15:0] r_uflow_cnt;
  logic [15:0] r_zero_cnt;

  assign w_out_fire = r2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_uflow_cnt <= '0;
      r_zero_cnt  <= '0;
    end else if (w_out_fire) begin
      if (r2_uflow && (r_uflow_cnt != 16'hFFFF)) r_uflow_cnt <= r_uflow_cnt + 16'd1;
      if (r2_zero && (r_zero_cnt != 16'hFFFF))   r_zero_cnt  <= r_zero_cnt + 16'd1;
    end
  end

  assign stat_uflow_cnt = r_uflow_cnt;
  assign stat_zero_cnt  = r_zero_cnt;
`endif

endmodule
